video_timing_driver: RTL and testbench

Raster timing generator and pixel fetch front end for the 1280×720 HDMI/VGA output path. It runs the horizontal and vertical counters and requests each active pixel by coordinate from the pixel generator, which returns `pixel_data` one clock later. It drives registered sync, data-enable and 24-bit RGB to the encoder. It also provides a frame-synchronous colour-bar test pattern for bring-up without the pixel generator.

---
 rtl/video_timing_driver_if.sv | 24 ++
 rtl/video_timing_driver.sv | 120 ++++++++++++
 tb/tb_video_timing_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_driver_if.sv
// rtl/video_timing_driver_if.sv - pixel request and video output bundle of the raster timing driver
interface video_timing_driver_if;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [23:0] pixel_data;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic        frame_start;

  modport master (
    output data_req, pixel_xpos, pixel_ypos,
    output video_hs, video_vs, video_de, video_rgb, frame_start,
    input  pixel_data
  );

  modport slave (
    input  data_req, pixel_xpos, pixel_ypos,
    input  video_hs, video_vs, video_de, video_rgb, frame_start,
    output pixel_data
  );
endinterface

// File: rtl/video_timing_driver.sv
// rtl/video_timing_driver.sv - raster counters, pixel fetch requests and registered sync/de/rgb outputs
module video_timing_driver #(
  parameter int   H_SYNC  = 40,
  parameter int   H_BACK  = 220,
  parameter int   H_DISP  = 1280,
  parameter int   H_FRONT = 110,
  parameter int   V_SYNC  = 5,
  parameter int   V_BACK  = 20,
  parameter int   V_DISP  = 720,
  parameter int   V_FRONT = 5,
  parameter logic HS_POL  = 1'b1,
  parameter logic VS_POL  = 1'b1
) (
  input  logic                  pixel_clk,
  input  logic                  sys_rst_n,
  input  logic                  pattern_en,
  video_timing_driver_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END  = 11'(H_SYNC);
  localparam logic [10:0] VS_END  = 11'(V_SYNC);
  localparam logic [10:0] HA      = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HA_END  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] REQ_BEG = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] REQ_END = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] VA      = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VA_END  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] BAR_W   = 11'(H_DISP / 8);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        pat_mode_q, pat_mode_d;
  logic        video_hs_q, video_hs_d;
  logic        video_vs_q, video_vs_d;
  logic        video_de_q, video_de_d;
  logic [23:0] video_rgb_q, video_rgb_d;
  logic        frame_start_q, frame_start_d;

  logic        frame_origin;
  logic        hs_d, vs_d, de_d, v_act, req;
  logic [10:0] bar_idx;
  logic [23:0] pat_rgb, src_rgb;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    // Pattern selection only changes at the frame origin so a frame is never mixed.
    pat_mode_d   = frame_origin ? pattern_en : pat_mode_q;

    hs_d  = h_cnt_q < HS_END;
    vs_d  = v_cnt_q < VS_END;
    v_act = (v_cnt_q >= VA) && (v_cnt_q < VA_END);
    de_d  = (h_cnt_q >= HA) && (h_cnt_q < HA_END) && v_act;
    // Requests lead de_d by one count to cover the generator's one-clock latency.
    req   = (h_cnt_q >= REQ_BEG) && (h_cnt_q < REQ_END) && v_act;

    bar_idx = (h_cnt_q - HA) / BAR_W;
    pat_rgb = 24'h000000;
    case (bar_idx)
      11'd0:   pat_rgb = 24'hFFFFFF;
      11'd1:   pat_rgb = 24'hFFFF00;
      11'd2:   pat_rgb = 24'h00FFFF;
      11'd3:   pat_rgb = 24'h00FF00;
      11'd4:   pat_rgb = 24'hFF00FF;
      11'd5:   pat_rgb = 24'hFF0000;
      11'd6:   pat_rgb = 24'h0000FF;
      default: pat_rgb = 24'h000000;
    endcase
    src_rgb = pat_mode_q ? pat_rgb : vid.pixel_data;

    video_hs_d    = hs_d ? HS_POL : ~HS_POL;
    video_vs_d    = vs_d ? VS_POL : ~VS_POL;
    video_de_d    = de_d;
    video_rgb_d   = de_d ? src_rgb : 24'h0;
    frame_start_d = frame_origin;
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pat_mode_q    <= 1'b0;
      video_hs_q    <= ~HS_POL;
      video_vs_q    <= ~VS_POL;
      video_de_q    <= 1'b0;
      video_rgb_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pat_mode_q    <= pat_mode_d;
      video_hs_q    <= video_hs_d;
      video_vs_q    <= video_vs_d;
      video_de_q    <= video_de_d;
      video_rgb_q   <= video_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.data_req    = req;
  assign vid.pixel_xpos  = req ? (h_cnt_q - REQ_BEG) : '0;
  assign vid.pixel_ypos  = req ? (v_cnt_q - VA) : '0;
  assign vid.video_hs    = video_hs_q;
  assign vid.video_vs    = video_vs_q;
  assign vid.video_de    = video_de_q;
  assign vid.video_rgb   = video_rgb_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_driver.sv
// tb/tb_video_timing_driver.sv - scoreboard bench for video_timing_driver on a reduced raster
module tb_video_timing_driver;
  localparam int HS = 4, HB = 5, HD = 16, HF = 3;
  localparam int VS = 2, VB = 3, VD = 6, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  localparam int BW = HD / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic pattern_en;

  always #5 clk = ~clk;

  video_timing_driver_if vif ();
  video_timing_driver_if vif_n ();

  assign vif_n.pixel_data = vif.pixel_data;

  video_timing_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixel_clk  (clk),
    .sys_rst_n  (rst_n),
    .pattern_en (pattern_en),
    .vid        (vif.master)
  );

  video_timing_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .pixel_clk  (clk),
    .sys_rst_n  (rst_n),
    .pattern_en (pattern_en),
    .vid        (vif_n.master)
  );

  int checks = 0;
  int failures = 0;
  int t;
  bit exp_pat;
  logic [23:0] sbq[$];
  int de_cnt, hs_cnt, vs_cnt, fs_cnt, first_de, fs_t, fs_gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gen_rgb(input int x, input int y);
    logic [10:0] xx;
    logic [7:0]  yy;
    xx = 11'(x);
    yy = 8'(y);
    return {yy, xx, 5'b0};
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / BW)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic clear_stats();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; first_de = -1;
  endtask

  // One clock: check the request side against the raster model, push the
  // expected pixel, advance, answer the request, then check the registered side.
  task automatic tick();
    int n, h, v;
    logic req, ede, cr;
    logic [10:0] cx, cy;
    logic [23:0] e;
    n = t % FT;
    h = n % HT;
    v = n / HT;
    req = (h >= HA - 1) && (h < HA + HD - 1) && (v >= VA) && (v < VA + VD);
    chk("data_req", vif.data_req, req);
    chk("xpos", vif.pixel_xpos, req ? h - (HA - 1) : 0);
    chk("ypos", vif.pixel_ypos, req ? v - VA : 0);
    if (n == 0) exp_pat = pattern_en;
    if (req) sbq.push_back(exp_pat ? bar_rgb(h - (HA - 1)) : gen_rgb(h - (HA - 1), v - VA));
    cr = vif.data_req;
    cx = vif.pixel_xpos;
    cy = vif.pixel_ypos;
    @(posedge clk);
    #1;
    t++;
    vif.pixel_data = cr ? {cy[7:0], cx, 5'b0} : 24'($urandom);
    ede = (h >= HA) && (h < HA + HD) && (v >= VA) && (v < VA + VD);
    chk("hs", vif.video_hs, (h < HS) ? 1 : 0);
    chk("vs", vif.video_vs, (v < VS) ? 1 : 0);
    chk("hs_inv", vif_n.video_hs, (h < HS) ? 0 : 1);
    chk("vs_inv", vif_n.video_vs, (v < VS) ? 0 : 1);
    chk("de", vif.video_de, ede);
    chk("de_inv", vif_n.video_de, ede);
    chk("frame_start", vif.frame_start, (n == 0) ? 1 : 0);
    chk("frame_start_inv", vif_n.frame_start, (n == 0) ? 1 : 0);
    if (ede) begin
      chk("sb_nonempty", (sbq.size() != 0) ? 1 : 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rgb", vif.video_rgb, e);
        chk("rgb_inv", vif_n.video_rgb, e);
      end
    end else begin
      chk("rgb_blank", vif.video_rgb, 0);
      chk("rgb_blank_inv", vif_n.video_rgb, 0);
    end
    if (vif.video_de === 1'b1) begin
      de_cnt++;
      if (first_de < 0) first_de = n;
    end
    if (vif.video_hs === 1'b1) hs_cnt++;
    if (vif.video_vs === 1'b1) vs_cnt++;
    if (vif.frame_start === 1'b1) begin
      fs_cnt++;
      if (fs_t >= 0) fs_gap = t - fs_t;
      fs_t = t;
    end
  endtask

  task automatic check_frame_stats(input string tag);
    chk({tag, "_de_clocks"}, de_cnt, HD * VD);
    chk({tag, "_hs_clocks"}, hs_cnt, HS * VT);
    chk({tag, "_vs_clocks"}, vs_cnt, VS * HT);
    chk({tag, "_fs_pulses"}, fs_cnt, 1);
    chk({tag, "_first_de"}, first_de, VA * HT + HA);
    chk({tag, "_sb_drained"}, sbq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hs"}, vif.video_hs, 0);
    chk({tag, "_vs"}, vif.video_vs, 0);
    chk({tag, "_hs_inv"}, vif_n.video_hs, 1);
    chk({tag, "_vs_inv"}, vif_n.video_vs, 1);
    chk({tag, "_de"}, vif.video_de, 0);
    chk({tag, "_rgb"}, vif.video_rgb, 0);
    chk({tag, "_fs"}, vif.frame_start, 0);
    chk({tag, "_req"}, vif.data_req, 0);
    chk({tag, "_xpos"}, vif.pixel_xpos, 0);
    chk({tag, "_ypos"}, vif.pixel_ypos, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    exp_pat = 1'b0;
    sbq.delete();
    fs_t = -1;
    fs_gap = -1;
  endtask

  initial begin
    rst_n = 1'b0;
    pattern_en = 1'b0;
    vif.pixel_data = 24'h0;
    #23;
    check_reset_outputs("reset");

    release_reset();
    clear_stats();
    repeat (FT) tick();
    check_frame_stats("frame0");

    repeat (FT / 2) tick();
    pattern_en = 1'b1;
    repeat (FT - FT / 2) tick();

    clear_stats();
    repeat (FT) tick();
    check_frame_stats("bars");
    chk("fs_period", fs_gap, FT);

    pattern_en = 1'b0;
    while ((t % FT) != (VA + 2) * HT + HA + 4) tick();
    chk("pre_reset_de", vif.video_de, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held_reset");

    pattern_en = 1'b1;
    release_reset();
    clear_stats();
    repeat (FT) tick();
    check_frame_stats("restart");
    tick();
    chk("restart_fs_period", fs_gap, FT);
    chk("final_sb_depth", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
